// File: rtl/medidor_de_clock.sv
// medidor_de_clock
//   Receives one slow divided clock (clk_lento) that is asynchronous to clk,
//   synchronizes it, and turns each rising edge into a one-cycle strobe that
//   downstream logic uses as a clock enable. It also measures the period in clk
//   cycles, declares lock after a run of consistent periods, and reports loss
//   when edges stop arriving.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   clk_lento  divided clock from a divider tap (asynchronous)
//   pulso      one-cycle strobe per synchronized rising edge of clk_lento
//   periodo    last measured period in clk cycles (PW bits)
//   valido     periodo holds at least one measurement since the last BUSCA
//   travado    lock indicator
//   perdido    one-cycle strobe when no edge arrives for TIMEOUT cycles
//
// state   | meaning
// --------+----------------------------------------------------------
// BUSCA   | waiting for the first edge, counter held at zero
// MEDINDO | measuring, counting consecutive consistent periods
// TRAVADO | locked, stays while successive periods remain consistent

module medidor_de_clock #(
  parameter int PW      = 32,
  parameter int TIMEOUT = 2**28,
  parameter int LOCK_N  = 4,
  parameter int TOL     = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_lento,
  output logic          pulso,
  output logic [PW-1:0] periodo,
  output logic          valido,
  output logic          travado,
  output logic          perdido
);

  typedef enum logic [1:0] {BUSCA, MEDINDO, TRAVADO} estado_t;

  localparam logic [PW-1:0] CNT_TC = PW'(TIMEOUT - 1);
  localparam logic [PW:0]   TOL_W  = (PW+1)'(TOL);
  localparam logic [3:0]    LOCK_W = 4'(LOCK_N);

  estado_t       estado, estado_nx;
  logic          s1, s2, s3;
  logic          det;
  logic [PW-1:0] cnt, cnt_nx;
  logic [PW-1:0] m;
  logic [3:0]    match, match_nx;
  logic [PW-1:0] periodo_nx;
  logic          valido_nx, travado_nx, perdido_nx;
  logic [PW:0]   dif, dif_abs;
  logic          consistente;
  logic          timeout;

  assign det = s2 & ~s3;
  assign m   = cnt + PW'(1);

  // Extra bit keeps the difference from wrapping when m < periodo.
  assign dif         = {1'b0, m} - {1'b0, periodo};
  assign dif_abs     = dif[PW] ? ((PW+1)'(0) - dif) : dif;
  assign consistente = (dif_abs <= TOL_W);

  // An edge arriving on the terminal count wins, so a period of exactly
  // TIMEOUT is still accepted.
  assign timeout = (estado != BUSCA) && (cnt == CNT_TC) && !det;

  always_comb begin
    estado_nx  = estado;
    periodo_nx = periodo;
    valido_nx  = valido;
    travado_nx = travado;
    match_nx   = match;
    perdido_nx = 1'b0;
    cnt_nx     = (estado == BUSCA || det) ? '0 : cnt + PW'(1);

    case (estado)
      BUSCA: begin
        if (det) begin
          estado_nx = MEDINDO;
          match_nx  = '0;
        end
      end
      MEDINDO: begin
        if (det) begin
          periodo_nx = m;
          if (!valido) begin
            valido_nx = 1'b1;
            match_nx  = '0;
          end else if (consistente) begin
            match_nx = match + 4'd1;
            if (match + 4'd1 == LOCK_W) begin
              estado_nx  = TRAVADO;
              travado_nx = 1'b1;
            end
          end else begin
            match_nx = '0;
          end
        end else if (timeout) begin
          estado_nx  = BUSCA;
          perdido_nx = 1'b1;
          travado_nx = 1'b0;
          valido_nx  = 1'b0;
          match_nx   = '0;
        end
      end
      TRAVADO: begin
        if (det) begin
          periodo_nx = m;
          if (!consistente) begin
            estado_nx  = MEDINDO;
            travado_nx = 1'b0;
            match_nx   = '0;
          end
        end else if (timeout) begin
          estado_nx  = BUSCA;
          perdido_nx = 1'b1;
          travado_nx = 1'b0;
          valido_nx  = 1'b0;
          match_nx   = '0;
        end
      end
      default: begin
        estado_nx = BUSCA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= BUSCA;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      pulso   <= 1'b0;
      cnt     <= '0;
      match   <= '0;
      periodo <= '0;
      valido  <= 1'b0;
      travado <= 1'b0;
      perdido <= 1'b0;
    end else begin
      estado  <= estado_nx;
      s1      <= clk_lento;
      s2      <= s1;
      s3      <= s2;
      pulso   <= det;
      cnt     <= cnt_nx;
      match   <= match_nx;
      periodo <= periodo_nx;
      valido  <= valido_nx;
      travado <= travado_nx;
      perdido <= perdido_nx;
    end
  end

endmodule

// File: tb/tb_medidor_de_clock.sv
module tb_medidor_de_clock;

  localparam int PW      = 16;
  localparam int TIMEOUT = 100;
  localparam int LOCK_N  = 3;
  localparam int TOL     = 1;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          clk_lento = 1'b0;
  logic          pulso;
  logic [PW-1:0] periodo;
  logic          valido;
  logic          travado;
  logic          perdido;

  medidor_de_clock #(
    .PW(PW), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N), .TOL(TOL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_lento(clk_lento),
    .pulso(pulso), .periodo(periodo), .valido(valido),
    .travado(travado), .perdido(perdido)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Event-level reference: pulses are scheduled from the stimulus rises,
  // periods are distances between pulse cycles, loss is a gap of TIMEOUT.
  bit m_busca  = 1'b1;
  bit m_valid  = 1'b0;
  bit m_lock   = 1'b0;
  bit m_prev   = 1'b0;
  bit m_pulso  = 1'b0;
  bit m_perd   = 1'b0;
  int m_per    = 0;
  int m_last   = 0;
  int m_streak = 0;
  int rise_q[$];

  wire [PW+3:0] obs_v = {pulso, valido, travado, perdido, periodo};
  wire [PW+3:0] exp_v = {m_pulso, m_valid, m_lock, m_perd, m_per[PW-1:0]};

  task automatic model_reset();
    m_busca  = 1'b1;
    m_valid  = 1'b0;
    m_lock   = 1'b0;
    m_prev   = 1'b0;
    m_pulso  = 1'b0;
    m_perd   = 1'b0;
    m_per    = 0;
    m_last   = 0;
    m_streak = 0;
    rise_q.delete();
  endtask

  task automatic model_step(input bit lento);
    int m;
    m_pulso = 1'b0;
    m_perd  = 1'b0;
    if (rise_q.size() > 0 && rise_q[0] == cyc) begin
      void'(rise_q.pop_front());
      m_pulso = 1'b1;
      if (m_busca) begin
        m_busca = 1'b0;
        m_last  = cyc;
      end else begin
        m      = cyc - m_last;
        m_last = cyc;
        if (!m_valid) begin
          m_valid  = 1'b1;
          m_streak = 0;
        end else if ((m - m_per) <= TOL && (m_per - m) <= TOL) begin
          if (!m_lock) begin
            m_streak++;
            if (m_streak == LOCK_N) m_lock = 1'b1;
          end
        end else begin
          m_streak = 0;
          m_lock   = 1'b0;
        end
        m_per = m;
      end
    end else if (!m_busca && (cyc - m_last) == TIMEOUT) begin
      m_perd   = 1'b1;
      m_busca  = 1'b1;
      m_valid  = 1'b0;
      m_lock   = 1'b0;
      m_streak = 0;
    end
    // A rise sampled on this edge shows up on pulso two edges later.
    if (lento && !m_prev) rise_q.push_back(cyc + 2);
    m_prev = lento;
  endtask

  task automatic tick(input bit lento);
    @(negedge clk);
    clk_lento = lento;
    @(posedge clk);
    cyc++;
    if (!reset_n) model_reset();
    else model_step(lento);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(i[1]);
      checks++;
      if (obs_v !== '0) $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, obs_v);
      else passed++;
    end
    clk_lento = 1'b0;
    reset_n   = 1'b1;
  endtask

  task automatic test_lock();
    int np = 0;
    int nperd = 0;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 20; i++) begin
        tick(i < 10);
        checks++;
        if (obs_v !== exp_v) $display("FAIL lock_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
        if (perdido) nperd++;
        if (pulso) begin
          np++;
          if (np == 2) begin
            checks++;
            if (periodo !== 16'd20 || valido !== 1'b1)
              $display("FAIL lock_first_period got periodo=%0d valido=%b want 20/1", periodo, valido);
            else passed++;
          end
          if (np == 5) begin
            checks++;
            if (travado !== 1'b1) $display("FAIL lock_fifth_pulse got travado=%b want 1", travado);
            else passed++;
          end
        end
      end
    end
    checks++;
    if (np != 6 || nperd != 0) $display("FAIL lock_counts got pulses=%0d perdido=%0d want 6/0", np, nperd);
    else passed++;
  endtask

  task automatic test_jitter();
    int waves[8]   = '{21, 20, 21, 25, 25, 25, 25, 20};
    int exp_m[8]   = '{20, 21, 20, 21, 25, 25, 25, 25};
    bit exp_lk[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int k = 0;
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < waves[w]; i++) begin
        tick(i < waves[w] / 2);
        checks++;
        if (obs_v !== exp_v) $display("FAIL jitter_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
        if (pulso) begin
          if (k < 8) begin
            checks++;
            if (periodo !== 16'(exp_m[k]) || travado !== exp_lk[k])
              $display("FAIL jitter_pulse%0d got periodo=%0d travado=%b want %0d/%b",
                       k, periodo, travado, exp_m[k], exp_lk[k]);
            else passed++;
          end
          k++;
        end
      end
    end
    checks++;
    if (k != 8) $display("FAIL jitter_pulse_count got %0d want 8", k);
    else passed++;
  endtask

  task automatic test_loss();
    int pc = -1;
    int pdc = -1;
    int nperd = 0;
    for (int i = 0; i < 130; i++) begin
      tick(i < 10);
      checks++;
      if (obs_v !== exp_v) $display("FAIL loss_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      else passed++;
      if (pulso) pc = cyc;
      if (perdido) begin
        nperd++;
        pdc = cyc;
      end
    end
    checks++;
    if (nperd != 1 || pdc - pc != TIMEOUT)
      $display("FAIL loss_timing got count=%0d delay=%0d want 1/%0d", nperd, pdc - pc, TIMEOUT);
    else passed++;
    checks++;
    if (travado !== 1'b0 || valido !== 1'b0 || periodo !== 16'd20)
      $display("FAIL loss_state got travado=%b valido=%b periodo=%0d want 0/0/20", travado, valido, periodo);
    else passed++;
  endtask

  task automatic test_boundary();
    int waves[4] = '{100, 100, 101, 30};
    int pcs[4]   = '{0, 0, 0, 0};
    int k = 0;
    int pdc = -1;
    int nperd = 0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < waves[w]; i++) begin
        tick(i < waves[w] / 2);
        checks++;
        if (obs_v !== exp_v) $display("FAIL boundary_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
        if (perdido) begin
          nperd++;
          pdc = cyc;
        end
        if (pulso) begin
          if (k < 4) pcs[k] = cyc;
          if (k == 1 || k == 2) begin
            checks++;
            if (periodo !== 16'd100 || valido !== 1'b1 || perdido !== 1'b0)
              $display("FAIL boundary_exact%0d got periodo=%0d valido=%b want 100/1", k, periodo, valido);
            else passed++;
          end
          if (k == 3) begin
            checks++;
            if (valido !== 1'b0) $display("FAIL boundary_reacquire got valido=%b want 0", valido);
            else passed++;
          end
          k++;
        end
      end
    end
    checks++;
    if (nperd != 1 || pdc - pcs[2] != TIMEOUT || pcs[3] - pdc != 1)
      $display("FAIL boundary_timeout got count=%0d delay=%0d next=%0d want 1/%0d/1",
               nperd, pdc - pcs[2], pcs[3] - pdc, TIMEOUT);
    else passed++;
  endtask

  task automatic test_random();
    int base;
    int p;
    int hi;
    base = $urandom_range(40, 12);
    for (int w = 0; w < 20; w++) begin
      if (w % 5 == 0) base = $urandom_range(40, 12);
      p  = base + $urandom_range(2, 0);
      hi = $urandom_range(p - 1, 1);
      for (int i = 0; i < p; i++) begin
        tick(i < hi);
        checks++;
        if (obs_v !== exp_v) $display("FAIL random_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    int np = 0;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 20; i++) begin
        tick(i < 10);
        checks++;
        if (obs_v !== exp_v) $display("FAIL relock_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
      end
    end
    checks++;
    if (travado !== 1'b1) $display("FAIL prereset_lock got travado=%b want 1", travado);
    else passed++;

    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_v !== '0) $display("FAIL async_reset got=%h want=0", obs_v);
    else passed++;
    model_reset();
    #1 reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick(i < 10);
      checks++;
      if (obs_v !== exp_v) $display("FAIL release_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      else passed++;
      if (pulso) np++;
    end
    checks++;
    if (np != 1) $display("FAIL release_high_pulse got %0d want 1", np);
    else passed++;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 20; i++) begin
        tick(i < 10);
        checks++;
        if (obs_v !== exp_v) $display("FAIL postreset_trace cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        else passed++;
        if (pulso) begin
          np++;
          if (np == 4 || np == 5) begin
            checks++;
            if (travado !== (np == 5)) $display("FAIL postreset_lock pulse%0d got travado=%b", np, travado);
            else passed++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_jitter();
    test_loss();
    test_boundary();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
